cache_miss_ctrl: RTL and testbench

Sequencing controller between the CPU memory stage, the direct-mapped data cache, and main memory. It serves read hits with zero wait states. On a read miss it stalls the CPU, fetches the word from memory over a valid/ready handshake, fills the cache and returns the data. Stores are write-through, no-allocate: the memory write is always issued, and the cache line is updated only on a hit. Miss and stall-cycle performance counters are exposed.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/store_lane_align.sv | 22 ++
 rtl/cache_miss_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and lane helpers for the cache miss controller
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte enables for a store; size 11 falls through to a full word.
  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr;
      SZ_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - store strobe generation and lane replication of right-aligned data
module store_lane_align
  import cache_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata
);

  // Replicate the low byte/half across all lanes so any strobe picks the right bytes.
  always_comb begin
    o_strb = lane_strb(i_size, i_addr_lo);
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - CPU/cache/memory sequencer: zero-wait hits, read-miss fill, write-through stores
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  cache_fill,
  output logic                  cache_wr,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic [3:0]            cache_wstrb,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_is_load;
  logic                  r_hit;
  logic [3:0]            r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_WIDTH-1:0]  r_miss_count;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;
  logic [3:0]            w_strb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_latch_rd;
  logic                  w_latch_wr;
  logic                  w_rdata_en;
  logic [ADDR_WIDTH-1:0] w_mem_addr;

  store_lane_align u_align (
    .i_size    (cpu_size),
    .i_addr_lo (cpu_addr[1:0]),
    .i_wdata   (cpu_wdata),
    .o_strb    (w_strb),
    .o_wdata   (w_wdata)
  );

  assign w_mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign miss_count   = r_miss_count;
  assign stall_cycles = r_stall_cycles;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and all handshake outputs; everything is held low while in reset.
  always_comb begin
    w_next      = r_state;
    w_latch_rd  = 1'b0;
    w_latch_wr  = 1'b0;
    w_rdata_en  = 1'b0;
    cpu_stall   = 1'b0;
    cpu_rvalid  = 1'b0;
    cpu_rdata   = '0;
    cache_fill  = 1'b0;
    cache_wr    = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    cache_wstrb = 4'b0000;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = 4'b0000;
    if (reset_n) begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            if (!cpu_we && cache_hit) begin
              cpu_rvalid = 1'b1;
              cpu_rdata  = cache_rdata;
            end else if (!cpu_we) begin
              cpu_stall  = 1'b1;
              w_latch_rd = 1'b1;
              w_next     = S_RD_REQ;
            end else begin
              cpu_stall  = 1'b1;
              w_latch_wr = 1'b1;
              w_next     = S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = w_mem_addr;
          if (mem_ready) w_next = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          cpu_stall = 1'b1;
          if (mem_rvalid) begin
            cache_fill  = 1'b1;
            cache_addr  = r_addr;
            cache_wdata = mem_rdata;
            w_rdata_en  = 1'b1;
            w_next      = S_DONE;
          end
        end
        S_WR_REQ: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = w_mem_addr;
          mem_wdata = r_wdata;
          mem_wstrb = r_strb;
          if (mem_ready) begin
            cache_wr = r_hit;
            if (r_hit) begin
              cache_addr  = r_addr;
              cache_wdata = r_wdata;
              cache_wstrb = r_strb;
            end
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          cpu_rvalid = r_is_load;
          if (r_is_load) cpu_rdata = r_rdata;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Transaction latches and saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr         <= '0;
      r_is_load      <= 1'b0;
      r_hit          <= 1'b0;
      r_strb         <= 4'b0000;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_latch_rd) begin
        r_addr    <= cpu_addr;
        r_is_load <= 1'b1;
      end
      if (w_latch_wr) begin
        r_addr    <= cpu_addr;
        r_is_load <= 1'b0;
        r_hit     <= cache_hit;
        r_strb    <= w_strb;
        r_wdata   <= w_wdata;
      end
      if (w_rdata_en) r_rdata <= mem_rdata;
      if (w_latch_rd && (r_miss_count != '1)) r_miss_count <= r_miss_count + CNT_ONE;
      if (cpu_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed vector bench for cache_miss_ctrl
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        cache_fill, cache_wr;
  logic [31:0] cache_addr, cache_wdata;
  logic [3:0]  cache_wstrb;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] miss_count, stall_cycles;

  int checks = 0;
  int failures = 0;
  int exp_stalls = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_fill(cache_fill), .cache_wr(cache_wr),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wstrb(cache_wstrb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .miss_count(miss_count), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] crdata;
    logic        exp_stall;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } hit_vec_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    int          rdy_dly;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
  } st_vec_t;

  hit_vec_t hv[4];
  st_vec_t  sv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk(name, {31'd0, cpu_stall}, {31'd0, exp});
    if (exp) exp_stalls++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    hv[0] = '{1'b1, 32'h20, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    hv[1] = '{1'b1, 32'h24, 1'b1, 32'h00000001, 1'b0, 1'b1, 32'h00000001};
    hv[2] = '{1'b0, 32'h28, 1'b1, 32'h55AA55AA, 1'b0, 1'b0, 32'h00000000};
    hv[3] = '{1'b1, 32'h2C, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF};

    sv[0] = '{2'b00, 32'h102, 32'h000000AB, 1'b1, 0, 4'b0100, 32'hABABABAB};
    sv[1] = '{2'b01, 32'h206, 32'h0000CAFE, 1'b0, 2, 4'b1100, 32'hCAFECAFE};
    sv[2] = '{2'b00, 32'h103, 32'h123456C3, 1'b0, 0, 4'b1000, 32'hC3C3C3C3};
    sv[3] = '{2'b01, 32'h201, 32'h1234BEEF, 1'b1, 1, 4'b0011, 32'hBEEFBEEF};
    sv[4] = '{2'b10, 32'h030, 32'h11223344, 1'b1, 0, 4'b1111, 32'h11223344};
    sv[5] = '{2'b11, 32'h035, 32'h99887766, 1'b0, 0, 4'b1111, 32'h99887766};

    reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cache_hit = 1'b0; cache_rdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // reset state, with a pending miss request held on the CPU side
    next_cycle(); next_cycle();
    sample();
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_fill", cache_fill, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_stalls", stall_cycles, 0);
    next_cycle();
    reset_n = 1'b1; cpu_req = 1'b0;

    // zero-wait load hits and idle cycles from the table
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      cpu_req = hv[i].req; cpu_we = 1'b0; cpu_addr = hv[i].addr;
      cache_hit = hv[i].hit; cache_rdata = hv[i].crdata;
      sample();
      chk_stall("hit_stall", hv[i].exp_stall);
      chk("hit_rvalid", cpu_rvalid, hv[i].exp_rvalid);
      chk("hit_rdata", cpu_rdata, hv[i].exp_rdata);
      chk("hit_mem_req", mem_req, 0);
    end
    next_cycle();
    cpu_req = 1'b0;
    sample();
    chk("hit_miss_count", miss_count, 0);
    chk("hit_stall_cycles", stall_cycles, 0);

    // load miss: ready on 2nd RD_REQ cycle, rvalid on 3rd RD_WAIT cycle
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h47; cache_hit = 1'b0; cache_rdata = 32'h0BAD0BAD;
    sample();
    chk_stall("lm_idle_stall", 1);
    chk("lm_idle_rvalid", cpu_rvalid, 0);
    chk("lm_idle_mem_req", mem_req, 0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hFEEDFACE;
    sample();
    chk_stall("lm_req0_stall", 1);
    chk("lm_req0_mem_req", mem_req, 1);
    chk("lm_req0_mem_we", mem_we, 0);
    chk("lm_req0_mem_addr", mem_addr, 32'h44);
    chk("lm_req0_no_fill", cache_fill, 0);
    next_cycle();
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    sample();
    chk_stall("lm_req1_stall", 1);
    chk("lm_req1_mem_req", mem_req, 1);
    chk("lm_req1_mem_addr", mem_addr, 32'h44);
    chk("lm_miss_count", miss_count, 1);
    next_cycle();
    mem_ready = 1'b0;
    sample();
    chk_stall("lm_wait0_stall", 1);
    chk("lm_wait0_mem_req", mem_req, 0);
    chk("lm_wait0_fill", cache_fill, 0);
    next_cycle();
    sample();
    chk_stall("lm_wait1_stall", 1);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678; cache_hit = 1'b1;
    sample();
    chk_stall("lm_wait2_stall", 1);
    chk("lm_fill", cache_fill, 1);
    chk("lm_fill_data", cache_wdata, 32'h12345678);
    chk("lm_fill_addr", cache_addr, 32'h47);
    chk("lm_fill_no_wr", cache_wr, 0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; cache_hit = 1'b0;
    sample();
    chk_stall("lm_done_stall", 0);
    chk("lm_done_rvalid", cpu_rvalid, 1);
    chk("lm_done_rdata", cpu_rdata, 32'h12345678);
    chk("lm_done_fill", cache_fill, 0);
    chk("lm_stall_cycles", stall_cycles, exp_stalls);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    chk("lm_after_stall", cpu_stall, 0);
    chk("lm_after_rvalid", cpu_rvalid, 0);
    chk("lm_after_miss_count", miss_count, 1);

    // write-through stores from the table; cache_hit flips after the IDLE cycle
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = sv[i].size; cpu_addr = sv[i].addr;
      cpu_wdata = sv[i].wdata; cache_hit = sv[i].hit; mem_ready = 1'b0;
      sample();
      chk_stall("st_idle_stall", 1);
      chk("st_idle_mem_req", mem_req, 0);
      next_cycle();
      cache_hit = ~sv[i].hit;
      for (int d = 0; d < sv[i].rdy_dly; d++) begin
        sample();
        chk_stall("st_hold_stall", 1);
        chk("st_hold_mem_req", mem_req, 1);
        chk("st_hold_wstrb", mem_wstrb, sv[i].exp_strb);
        chk("st_hold_wdata", mem_wdata, sv[i].exp_data);
        chk("st_hold_cache_wr", cache_wr, 0);
        chk("st_hold_fill", cache_fill, 0);
        next_cycle();
      end
      mem_ready = 1'b1;
      sample();
      chk_stall("st_req_stall", 1);
      chk("st_mem_req", mem_req, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", mem_addr, {sv[i].addr[31:2], 2'b00});
      chk("st_mem_wstrb", mem_wstrb, sv[i].exp_strb);
      chk("st_mem_wdata", mem_wdata, sv[i].exp_data);
      chk("st_cache_wr", cache_wr, sv[i].hit);
      chk("st_cache_wstrb", cache_wstrb, sv[i].hit ? sv[i].exp_strb : 4'b0000);
      chk("st_cache_wdata", cache_wdata, sv[i].hit ? sv[i].exp_data : 32'h0);
      chk("st_fill", cache_fill, 0);
      next_cycle();
      mem_ready = 1'b0;
      sample();
      chk_stall("st_done_stall", 0);
      chk("st_done_rvalid", cpu_rvalid, 0);
      chk("st_done_cache_wr", cache_wr, 0);
      chk("st_done_mem_req", mem_req, 0);
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
    end
    sample();
    chk("st_stall_cycles", stall_cycles, exp_stalls);
    chk("st_miss_count", miss_count, 1);

    // asynchronous reset while waiting for read data, then a stale response
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cache_hit = 1'b0;
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    sample();
    chk("rw_wait_stall", cpu_stall, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_rst_stall", cpu_stall, 0);
    chk("rw_rst_mem_req", mem_req, 0);
    chk("rw_rst_miss", miss_count, 0);
    chk("rw_rst_stalls", stall_cycles, 0);
    next_cycle();
    reset_n = 1'b1; cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
    sample();
    chk("rw_late_fill", cache_fill, 0);
    chk("rw_late_stall", cpu_stall, 0);
    chk("rw_late_rvalid", cpu_rvalid, 0);
    next_cycle();
    mem_rvalid = 1'b0;
    sample();
    chk("rw_after_rvalid", cpu_rvalid, 0);
    chk("rw_after_stalls", stall_cycles, 0);
    exp_stalls = 0;

    // asynchronous reset while a store request is outstanding
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h40; cpu_wdata = 32'h5A5A5A5A;
    next_cycle();
    sample();
    chk("wr_req_mem_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("wr_rst_mem_req", mem_req, 0);
    chk("wr_rst_stall", cpu_stall, 0);
    next_cycle();
    reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    sample();
    chk("wr_after_mem_req", mem_req, 0);

    // stall counter saturation: preload one below all-ones, then two stores
    next_cycle();
    force dut.r_stall_cycles = 32'hFFFFFFFE;
    next_cycle();
    release dut.r_stall_cycles;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h60; cpu_wdata = 32'h1;
      cache_hit = 1'b0;
      next_cycle();
      mem_ready = 1'b1;
      next_cycle();
      mem_ready = 1'b0;
      sample();
      chk("sat_done_stall", cpu_stall, 0);
      chk("sat_stall_cycles", stall_cycles, 32'hFFFFFFFF);
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
